perceptron_sum_pipe: RTL
========================

# perceptron_sum_pipe

Pipelined, parametrised signed dot-product unit for the perceptron predictor. It computes bias + Σ(±wᵢ), where each weight's sign is selected by the corresponding global-history bit, using a 3:2 carry-save tree followed by one carry-propagate adder. It generalises the fixed 12×3-bit unsigned compressor to N signed W-bit operands, with pipeline registers, valid/ready flow control and a low-confidence flag used by the training logic. It sits between the weight-table read port and the predict/train decision logic.

## Interface
- N, 12: number of weight operands (2..64)
- W, 8: weight and bias width, two's complement (2..16)
- STAGES, 2: register stages from input to output (1..4)
- THETA, 30: training threshold, non-negative, representable in OUT_W bits
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand set present
- in_ready  out  1  unit can accept operands this cycle
- in_weights  in  N*W  weight i at bits [i*W +: W], signed
- in_bias  in  W  bias weight, signed, always added
- in_hist  in  N  bit i = 1 adds +wᵢ; bit i = 0 adds −wᵢ
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_sum  out  OUT_W  signed sum
- out_taken  out  1  prediction, 1 when out_sum ≥ 0
- out_low_conf  out  1  |out_sum| ≤ THETA (see Configuration)

## Operation
- OUT_W = W + clog2(N+1) + 1. The sum never overflows.
- Negation: each operand with hᵢ = 0 enters the tree as ~wᵢ. The count of zero history bits is injected as correction ones at LSB weight, using spare carry-in slots or a small popcount term, so the result is exact two's complement.
- Every operand is sign-extended to OUT_W before compression. The tree reduces N+1 operands plus the correction term to two vectors, then a single CPA produces out_sum.
- Tree levels are split as evenly as possible across STAGES register boundaries. The CPA is always in the final stage. Stage registers hold the data plus one valid bit.
- Global advance: adv = !out_valid || out_ready.
  - All stage registers load only when adv = 1.
  - in_ready = adv.
  - A transfer happens on in_valid && in_ready.
  - Bubbles are not collapsed.
- out_taken = ~out_sum[OUT_W-1].
- Magnitude for the confidence check: the two's-complement absolute value, computed in OUT_W bits. This cannot overflow because of the extra bit in OUT_W.

## Timing
- Latency: a set accepted at edge k appears with out_valid = 1 after edge k+STAGES−1, i.e. on the cycle following STAGES edges of advance.
- Throughput: one result per cycle while out_ready = 1.
- When out_valid && !out_ready: the whole pipe freezes, in_ready = 0, and out_sum, out_taken and out_low_conf hold stable.
- Reset (asynchronous assert, synchronous deassert by the system) clears:
  - all valid bits, so out_valid = 0;
  - all data registers, so out_sum = 0, out_taken = 1, out_low_conf = 0.
- Reset mid-operation discards all in-flight sets. No partial output is produced.
- in_ready is 1 in the first cycle after reset.
- in_valid = 0 with adv = 1 inserts a bubble, and its slot's valid bit becomes 0.
- Outputs depend only on registers. in_ready is combinational from out_valid and out_ready only.

## Configuration
- PERCEPTRON_SUM_LOWCONF_EN defined:
  - the magnitude and THETA compare is built in the final stage;
  - out_low_conf = (|out_sum| ≤ THETA), registered with out_sum.
- Not defined:
  - no compare logic is built;
  - out_low_conf is tied to 0;
  - the port list is unchanged.

## Structure
- Shared package perceptron_pkg holds:
  - a constant clog2 function;
  - an out_width(N, W) function returning OUT_W;
  - a weight_t typedef parameterised by W via the package's localparam default of 8;
  - the default THETA as a constant.
- One sub-module: csa_3to2, a bit-vector 3:2 compressor of parameter width. It is instantiated per tree level from a generate loop. The existing fullAdder and halfAdder cells are acceptable as its leaves.

## Test plan
- N=12, W=8, bias=0, all wᵢ=5, hist=all 1 → out_sum=60, out_taken=1; with out_low_conf enabled (THETA=30), out_low_conf=0.
- All wᵢ=−128, hist=all 0, bias=−128 → out_sum = 12·128 − 128 = 1408, no overflow. All wᵢ=−128, hist=all 1, bias=−128 → out_sum = −1664, out_taken=0.
- wᵢ=1, hist=0x555, bias=−30 → out_sum=−30, out_low_conf=1. bias=−31 → out_sum=−31, out_low_conf=0.
- Back-to-back stream of 20 random sets with out_ready=1 → 20 results in order, each exactly STAGES cycles after acceptance, matching a reference model.
- out_ready held 0 for 5 cycles with a full pipe → in_ready=0, outputs stable, no set lost or duplicated after release.
- reset_n asserted with 2 sets in flight → out_valid=0 and out_sum=0 immediately. After release, the first new set's result appears STAGES cycles after acceptance.

Source files
------------

// File: rtl/perceptron_pkg.sv
// Shared constants, types and elaboration-time helpers for the perceptron sum pipeline.
package perceptron_pkg;

  localparam int WEIGHT_W      = 8;
  localparam int THETA_DEFAULT = 30;

  typedef logic signed [WEIGHT_W-1:0] weight_t;

  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int out_width(input int n, input int w);
    return w + clog2(n + 1) + 1;
  endfunction

  // Operand count after lvl levels of 3:2 compression.
  function automatic int ops_at_level(input int m, input int lvl);
    int c = m;
    for (int i = 0; i < lvl; i++) c = c - c / 3;
    return c;
  endfunction

  function automatic int tree_levels(input int m);
    int c = m;
    int l = 0;
    while (c > 2) begin
      c = c - c / 3;
      l++;
    end
    return l;
  endfunction

  // Boundary b of s-1 sits after level ceil(b*t/s), spreading t levels across s stages.
  function automatic bit is_boundary(input int lvl, input int t, input int s);
    for (int b = 1; b < s; b++)
      if ((b * t + s - 1) / s == lvl) return 1'b1;
    return 1'b0;
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// Bit-vector 3:2 compressor. carry_o is already shifted to weight 2; the MSB carry
// is dropped because all tree arithmetic is modulo 2^WIDTH.
module csa_3to2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] carry_o
);

  assign sum_o      = a_i ^ b_i ^ c_i;
  assign carry_o[0] = 1'b0;

  genvar gi;
  for (gi = 0; gi < WIDTH - 1; gi++) begin : g_maj
    assign carry_o[gi+1] = (a_i[gi] & b_i[gi]) | (a_i[gi] & c_i[gi]) | (b_i[gi] & c_i[gi]);
  end

endmodule

// File: rtl/perceptron_sum_pipe.sv
// Pipelined bias + sum(+/-w_i) via a carry-save tree and one final CPA.
// Define PERCEPTRON_SUM_LOWCONF_EN to build the |sum| <= THETA low-confidence flag.
module perceptron_sum_pipe
  import perceptron_pkg::*;
#(
  parameter int N      = 12,
  parameter int W      = WEIGHT_W,
  parameter int STAGES = 2,
  parameter int THETA  = THETA_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N*W-1:0]             in_weights,
  input  logic [W-1:0]               in_bias,
  input  logic [N-1:0]               in_hist,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [out_width(N,W)-1:0]  out_sum,
  output logic                       out_taken,
  output logic                       out_low_conf
);

  localparam int OUT_W = out_width(N, W);
  localparam int M     = N + 2;
  localparam int CW    = clog2(N + 1);
  localparam int L     = tree_levels(M);
  localparam int T     = (L > STAGES - 1) ? L : STAGES - 1;

  logic              adv;
  logic [STAGES-1:0] vld_q;
  logic [CW-1:0]     zero_cnt;

  assign out_valid = vld_q[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_q <= '0;
    else if (adv) vld_q <= (vld_q << 1) | STAGES'(in_valid);
  end

  // Each negated operand enters as ~w; the missing +1s come back as this count.
  always_comb begin
    zero_cnt = '0;
    for (int i = 0; i < N; i++)
      if (!in_hist[i]) zero_cnt = zero_cnt + CW'(1);
  end

  genvar gl, gi;
  for (gl = 0; gl <= T; gl++) begin : g_lvl
    localparam int CNT = ops_at_level(M, gl);
    logic [OUT_W-1:0] ops [CNT];

    if (gl == 0) begin : g_src
      for (gi = 0; gi < N; gi++) begin : g_w
        logic [OUT_W-1:0] ext;
        assign ext     = OUT_W'($signed(in_weights[gi*W +: W]));
        assign ops[gi] = in_hist[gi] ? ext : ~ext;
      end
      assign ops[N]   = OUT_W'($signed(in_bias));
      assign ops[N+1] = OUT_W'(zero_cnt);
    end else begin : g_red
      localparam int PCNT = ops_at_level(M, gl - 1);
      localparam int GRP  = PCNT / 3;
      logic [OUT_W-1:0] red_d [CNT];

      for (gi = 0; gi < GRP; gi++) begin : g_csa
        csa_3to2 #(.WIDTH(OUT_W)) u_csa (
          .a_i    (g_lvl[gl-1].ops[3*gi]),
          .b_i    (g_lvl[gl-1].ops[3*gi+1]),
          .c_i    (g_lvl[gl-1].ops[3*gi+2]),
          .sum_o  (red_d[2*gi]),
          .carry_o(red_d[2*gi+1])
        );
      end
      for (gi = 3 * GRP; gi < PCNT; gi++) begin : g_pass
        assign red_d[gi-GRP] = g_lvl[gl-1].ops[gi];
      end

      if (is_boundary(gl, T, STAGES)) begin : g_reg
        logic [OUT_W-1:0] ops_q [CNT];
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            for (int i = 0; i < CNT; i++) ops_q[i] <= '0;
          end else if (adv) begin
            ops_q <= red_d;
          end
        end
        assign ops = ops_q;
      end else begin : g_comb
        assign ops = red_d;
      end
    end
  end

  logic [OUT_W-1:0] sum_d, sum_q;
  logic             taken_q;

  assign sum_d = g_lvl[T].ops[0] + g_lvl[T].ops[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q   <= '0;
      taken_q <= 1'b1;
    end else if (adv) begin
      sum_q   <= sum_d;
      taken_q <= ~sum_d[OUT_W-1];
    end
  end

  assign out_sum   = sum_q;
  assign out_taken = taken_q;

`ifdef PERCEPTRON_SUM_LOWCONF_EN
  logic [OUT_W-1:0] mag_d;
  logic             low_conf_q;

  // The extra top bit of OUT_W keeps the negation of the most negative sum in range.
  assign mag_d = sum_d[OUT_W-1] ? -sum_d : sum_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  low_conf_q <= 1'b0;
    else if (adv)  low_conf_q <= (mag_d <= OUT_W'(THETA));
  end

  assign out_low_conf = low_conf_q;
`else
  assign out_low_conf = 1'b0;
`endif

endmodule
